// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings, FSM states and the
// default operand width.
package mul_div_unit_pkg;

  localparam int unsigned Width = 32;

  localparam logic [2:0] MD_MULTU = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_DIVU  = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix
  } mdState_e;

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the control unit (master) and the multiply/divide unit (slave).
interface mul_div_unit_if #(
  parameter int unsigned WIDTH = mul_div_unit_pkg::Width
);
  logic             Start_in;
  logic [2:0]       Op_in;
  logic [WIDTH-1:0] OperandA_in;
  logic [WIDTH-1:0] OperandB_in;
  logic             Busy_out;
  logic             Done_out;
  logic             DivZero_out;
  logic [WIDTH-1:0] HI_out;
  logic [WIDTH-1:0] LO_out;

  modport master (
    output Start_in, Op_in, OperandA_in, OperandB_in,
    input  Busy_out, Done_out, DivZero_out, HI_out, LO_out
  );

  modport slave (
    input  Start_in, Op_in, OperandA_in, OperandB_in,
    output Busy_out, Done_out, DivZero_out, HI_out, LO_out
  );
endinterface

// File: rtl/mul_div_unit_md_sign_fix.sv
// Sign handling around the unsigned iterative core: magnitudes on entry, result negation at the
// end. Shared by multiply and divide.
module md_sign_fix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rawA_i,
  input  logic [WIDTH-1:0] rawB_i,
  input  logic             isSigned_i,
  output logic [WIDTH-1:0] magA_o,
  output logic [WIDTH-1:0] magB_o,
  output logic             signA_o,
  output logic             signB_o,
  input  logic             isMul_i,
  input  logic [WIDTH-1:0] resHi_i,
  input  logic [WIDTH-1:0] resLo_i,
  input  logic             negRes_i,
  input  logic             negRem_i,
  output logic [WIDTH-1:0] fixHi_o,
  output logic [WIDTH-1:0] fixLo_o
);

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prodNeg;

  assign signA_o = isSigned_i & rawA_i[WIDTH-1];
  assign signB_o = isSigned_i & rawB_i[WIDTH-1];
  // -2^(W-1) maps onto itself, which is the correct unsigned magnitude.
  assign magA_o  = signA_o ? (~rawA_i + WIDTH'(1)) : rawA_i;
  assign magB_o  = signB_o ? (~rawB_i + WIDTH'(1)) : rawB_i;

  assign prod    = {resHi_i, resLo_i};
  assign prodNeg = ~prod + (2*WIDTH)'(1);

  always_comb begin
    fixHi_o = resHi_i;
    fixLo_o = resLo_i;
    if (isMul_i) begin
      {fixHi_o, fixLo_o} = negRes_i ? prodNeg : prod;
    end else begin
      fixLo_o = negRes_i ? (~resLo_i + WIDTH'(1)) : resLo_i;
      fixHi_o = negRem_i ? (~resHi_i + WIDTH'(1)) : resHi_i;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers: one shift-add or restoring
// shift-subtract step per cycle, sign correction in a final FIX cycle.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = Width
) (
  input logic          CLK_in,
  input logic          RST_in,
  mul_div_unit_if.slave md
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  mdState_e           stateQ, stateD;
  logic [WIDTH-1:0]   hiQ, hiD, loQ, loD;
  logic [WIDTH-1:0]   magAQ, magAD, magBQ, magBD;
  logic [2*WIDTH-1:0] accQ, accD;
  logic [WIDTH:0]     remQ, remD;
  logic [CntW-1:0]    cntQ, cntD;
  logic               isDivQ, isDivD, negQ, negD, negRemQ, negRemD;
  logic               busyQ, busyD, doneQ, doneD, divZeroQ, divZeroD;

  logic               isMulOp, isDivOp, isSignedOp;
  logic [WIDTH-1:0]   entMagA, entMagB, fixHi, fixLo;
  logic               entSignA, entSignB;
  logic [WIDTH:0]     mulSum, divShift, divDiff;
  logic               divOk;

  assign isMulOp    = (md.Op_in == MD_MULTU) || (md.Op_in == MD_MULT);
  assign isDivOp    = (md.Op_in == MD_DIVU) || (md.Op_in == MD_DIV);
  assign isSignedOp = (md.Op_in == MD_MULT) || (md.Op_in == MD_DIV);

  md_sign_fix #(
    .WIDTH(WIDTH)
  ) uSignFix (
    .rawA_i    (md.OperandA_in),
    .rawB_i    (md.OperandB_in),
    .isSigned_i(isSignedOp),
    .magA_o    (entMagA),
    .magB_o    (entMagB),
    .signA_o   (entSignA),
    .signB_o   (entSignB),
    .isMul_i   (!isDivQ),
    .resHi_i   (isDivQ ? remQ[WIDTH-1:0] : accQ[2*WIDTH-1:WIDTH]),
    .resLo_i   (accQ[WIDTH-1:0]),
    .negRes_i  (negQ),
    .negRem_i  (negRemQ),
    .fixHi_o   (fixHi),
    .fixLo_o   (fixLo)
  );

  // Multiply: multiplier sits in the low half and is shifted out as the product shifts in.
  assign mulSum   = {1'b0, accQ[2*WIDTH-1:WIDTH]} + (accQ[0] ? {1'b0, magAQ} : '0);
  // Divide: dividend shifts out of the low half, quotient bits shift in behind it.
  assign divShift = {remQ[WIDTH-1:0], accQ[WIDTH-1]};
  assign divDiff  = divShift - {1'b0, magBQ};
  assign divOk    = !divDiff[WIDTH];

  always_comb begin
    stateD   = stateQ;
    hiD      = hiQ;
    loD      = loQ;
    magAD    = magAQ;
    magBD    = magBQ;
    accD     = accQ;
    remD     = remQ;
    cntD     = cntQ;
    isDivD   = isDivQ;
    negD     = negQ;
    negRemD  = negRemQ;
    busyD    = busyQ;
    doneD    = 1'b0;
    divZeroD = divZeroQ;
    unique case (stateQ)
      StIdle: begin
        if (md.Start_in) begin
          if (md.Op_in == MD_MTHI) begin
            hiD = md.OperandA_in;
          end else if (md.Op_in == MD_MTLO) begin
            loD = md.OperandA_in;
          end else if (isMulOp || isDivOp) begin
            magAD    = entMagA;
            magBD    = entMagB;
            cntD     = '0;
            busyD    = 1'b1;
            divZeroD = 1'b0;
            isDivD   = isDivOp;
            negD     = entSignA ^ entSignB;
            negRemD  = entSignA;
            remD     = '0;
            stateD   = StRun;
            if (isMulOp) begin
              accD = {{WIDTH{1'b0}}, entMagB};
            end else if (entMagB == '0) begin
              // Preload the divide-by-zero result; FIX restores A's sign on HI.
              accD   = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
              remD   = {1'b0, entMagA};
              negD   = 1'b0;
              stateD = StFix;
            end else begin
              accD = {{WIDTH{1'b0}}, entMagA};
            end
          end
        end
      end
      StRun: begin
        if (isDivQ) begin
          remD = divOk ? divDiff : divShift;
          accD = {accQ[2*WIDTH-1:WIDTH], accQ[WIDTH-2:0], divOk};
        end else begin
          accD = {mulSum, accQ[WIDTH-1:1]};
        end
        cntD = cntQ + CntW'(1);
        if (cntQ == CntW'(WIDTH - 1)) stateD = StFix;
      end
      StFix: begin
        hiD      = fixHi;
        loD      = fixLo;
        busyD    = 1'b0;
        doneD    = 1'b1;
        divZeroD = isDivQ && (magBQ == '0);
        stateD   = StIdle;
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge CLK_in or posedge RST_in) begin
    if (RST_in) begin
      stateQ   <= StIdle;
      hiQ      <= '0;
      loQ      <= '0;
      magAQ    <= '0;
      magBQ    <= '0;
      accQ     <= '0;
      remQ     <= '0;
      cntQ     <= '0;
      isDivQ   <= 1'b0;
      negQ     <= 1'b0;
      negRemQ  <= 1'b0;
      busyQ    <= 1'b0;
      doneQ    <= 1'b0;
      divZeroQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      hiQ      <= hiD;
      loQ      <= loD;
      magAQ    <= magAD;
      magBQ    <= magBD;
      accQ     <= accD;
      remQ     <= remD;
      cntQ     <= cntD;
      isDivQ   <= isDivD;
      negQ     <= negD;
      negRemQ  <= negRemD;
      busyQ    <= busyD;
      doneQ    <= doneD;
      divZeroQ <= divZeroD;
    end
  end

  assign md.Busy_out    = busyQ;
  assign md.Done_out    = doneQ;
  assign md.DivZero_out = divZeroQ;
  assign md.HI_out      = hiQ;
  assign md.LO_out      = loQ;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: transaction-level model checked every cycle, plus
// directed cases with hand-computed results.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mul_div_unit_if #(.WIDTH(W)) mdIf ();

  mul_div_unit #(
    .WIDTH(W)
  ) dut (
    .CLK_in(clk),
    .RST_in(rst),
    .md    (mdIf)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Architectural result of one MUL/DIV op, from plain 64-bit arithmetic.
  function automatic void calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] hi, output logic [31:0] lo);
    longint          sa, sb, q, r;
    longint unsigned p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = '0;
    lo = '0;
    case (op)
      MD_MULTU: begin
        p  = {32'd0, a} * {32'd0, b};
        hi = p[63:32];
        lo = p[31:0];
      end
      MD_MULT: begin
        q  = sa * sb;
        hi = q[63:32];
        lo = q[31:0];
      end
      MD_DIVU, MD_DIV: begin
        if (b == 32'd0) begin
          hi = a;
          lo = '1;
        end else if (op == MD_DIVU) begin
          hi = a % b;
          lo = a / b;
        end else begin
          q  = sa / sb;
          r  = sa % sb;
          hi = r[31:0];
          lo = q[31:0];
        end
      end
      default: ;
    endcase
  endfunction

  // Reference model state
  bit          mBusy = 0, mDone = 0, mDz = 0, pendDz = 0;
  logic [31:0] mHi = '0, mLo = '0, pendHi = '0, pendLo = '0;
  int          mLeft = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mBusy = 0; mDone = 0; mDz = 0; mHi = '0; mLo = '0; mLeft = 0;
    end else begin
      mDone = 0;
      if (mBusy) begin
        mLeft--;
        if (mLeft == 0) begin
          mBusy = 0; mDone = 1; mHi = pendHi; mLo = pendLo; mDz = pendDz;
        end
      end else if (mdIf.Start_in) begin
        case (mdIf.Op_in)
          MD_MTHI: mHi = mdIf.OperandA_in;
          MD_MTLO: mLo = mdIf.OperandA_in;
          MD_MULTU, MD_MULT, MD_DIVU, MD_DIV: begin
            calc(mdIf.Op_in, mdIf.OperandA_in, mdIf.OperandB_in, pendHi, pendLo);
            pendDz = (mdIf.Op_in[1] && mdIf.OperandB_in == 32'd0);
            mDz    = 0;
            mBusy  = 1;
            mLeft  = pendDz ? 1 : W + 1;
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("busy", 64'(mdIf.Busy_out), 64'(mBusy));
      check("done", 64'(mdIf.Done_out), 64'(mDone));
      check("divzero", 64'(mdIf.DivZero_out), 64'(mDz));
      check("hi", 64'(mdIf.HI_out), 64'(mHi));
      check("lo", 64'(mdIf.LO_out), 64'(mLo));
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int busyCyc, output bit gotDone);
    busyCyc = 0;
    gotDone = 0;
    @(posedge clk); #1;
    mdIf.Start_in = 1'b1; mdIf.Op_in = op; mdIf.OperandA_in = a; mdIf.OperandB_in = b;
    @(posedge clk); #1;
    mdIf.Start_in = 1'b0; mdIf.OperandA_in = $urandom; mdIf.OperandB_in = $urandom;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mdIf.Busy_out) busyCyc++;
      if (mdIf.Done_out) begin
        gotDone = 1;
        break;
      end
    end
    check("done_seen", 64'(gotDone), 64'd1);
  endtask

  logic [31:0] th, tl;
  int          bc;
  bit          gd, sawDone;

  initial begin
    rst = 1'b1;
    mdIf.Start_in = 1'b0; mdIf.Op_in = '0; mdIf.OperandA_in = '0; mdIf.OperandB_in = '0;

    // Pin the model with hand-computed values
    calc(MD_MULT, 32'hFFFF_FFFD, 32'd7, th, tl);
    check("model_mult", {th, tl}, 64'hFFFF_FFFF_FFFF_FFEB);
    calc(MD_DIV, 32'hFFFF_FFF9, 32'd2, th, tl);
    check("model_div", {th, tl}, 64'hFFFF_FFFF_FFFF_FFFD);

    repeat (2) @(negedge clk);
    check("rst_busy", 64'(mdIf.Busy_out), 64'd0);
    check("rst_hi", 64'(mdIf.HI_out), 64'd0);
    #1 rst = 1'b0;

    runOp(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, gd);
    check("multu_busy_cycles", 64'(bc), 64'd33);
    check("multu_hilo", {mdIf.HI_out, mdIf.LO_out}, 64'hFFFF_FFFE_0000_0001);
    runOp(MD_MULT, 32'hFFFF_FFFD, 32'd7, bc, gd);
    check("mult_hilo", {mdIf.HI_out, mdIf.LO_out}, 64'hFFFF_FFFF_FFFF_FFEB);
    runOp(MD_DIVU, 32'd100, 32'd7, bc, gd);
    check("divu_hilo", {mdIf.HI_out, mdIf.LO_out}, {32'd2, 32'd14});
    runOp(MD_DIV, 32'hFFFF_FFF9, 32'd2, bc, gd);
    check("div_neg", {mdIf.HI_out, mdIf.LO_out}, 64'hFFFF_FFFF_FFFF_FFFD);
    runOp(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, bc, gd);
    check("div_ovf", {mdIf.HI_out, mdIf.LO_out}, 64'h0000_0000_8000_0000);
    runOp(MD_DIV, 32'd5, 32'd0, bc, gd);
    check("dz_busy_cycles", 64'(bc), 64'd1);
    check("dz_hilo", {mdIf.HI_out, mdIf.LO_out}, 64'h0000_0005_FFFF_FFFF);
    check("dz_flag", 64'(mdIf.DivZero_out), 64'd1);
    runOp(MD_MULTU, 32'd2, 32'd3, bc, gd);
    check("dz_clear", 64'(mdIf.DivZero_out), 64'd0);
    check("multu_small_lo", 64'(mdIf.LO_out), 64'd6);

    // MTHI in idle
    @(posedge clk); #1;
    mdIf.Start_in = 1'b1; mdIf.Op_in = MD_MTHI; mdIf.OperandA_in = 32'h1234;
    @(posedge clk); #1;
    mdIf.Start_in = 1'b0;
    @(negedge clk);
    check("mthi_hi", 64'(mdIf.HI_out), 64'h1234);
    check("mthi_nodone", 64'(mdIf.Done_out), 64'd0);

    // MTLO and restart attempts while busy are ignored
    @(posedge clk); #1;
    mdIf.Start_in = 1'b1; mdIf.Op_in = MD_MULTU; mdIf.OperandA_in = 32'd3; mdIf.OperandB_in = 32'd3;
    @(posedge clk); #1;
    mdIf.Op_in = MD_MTLO; mdIf.OperandA_in = 32'hDEAD;
    repeat (3) @(posedge clk); #1;
    mdIf.Op_in = MD_MULTU; mdIf.OperandA_in = 32'd7; mdIf.OperandB_in = 32'd7;
    repeat (3) @(posedge clk); #1;
    mdIf.Start_in = 1'b0;
    gd = 0;
    for (int i = 0; i < 100 && !gd; i++) begin
      @(negedge clk);
      gd = mdIf.Done_out;
    end
    check("busy_ignore_done", 64'(gd), 64'd1);
    check("busy_ignore_hilo", {mdIf.HI_out, mdIf.LO_out}, 64'd9);

    // Reset mid-operation
    @(posedge clk); #1;
    mdIf.Start_in = 1'b1; mdIf.Op_in = MD_DIVU; mdIf.OperandA_in = 32'd100; mdIf.OperandB_in = 32'd7;
    @(posedge clk); #1;
    mdIf.Start_in = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    check("midrst_hilo", {mdIf.HI_out, mdIf.LO_out}, 64'd0);
    check("midrst_busy", 64'(mdIf.Busy_out), 64'd0);
    sawDone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      sawDone |= mdIf.Done_out;
    end
    check("midrst_nodone", 64'(sawDone), 64'd0);
    runOp(MD_MULTU, 32'd4, 32'd5, bc, gd);
    check("post_rst_busy_cycles", 64'(bc), 64'd33);
    check("post_rst_lo", 64'(mdIf.LO_out), 64'd20);

    // Random traffic, including starts in the Done cycle and while busy
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      mdIf.Start_in    = ($urandom_range(0, 3) == 0);
      mdIf.Op_in       = 3'($urandom_range(0, 7));
      mdIf.OperandA_in = pick();
      mdIf.OperandB_in = pick();
      if (c == 2000) begin
        rst = 1'b1;
        #2 rst = 1'b0;
      end
    end
    @(posedge clk); #1;
    mdIf.Start_in = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("final_idle", 64'(mdIf.Busy_out), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
